// File: rtl/minmax_reduce_if.sv
// minmax_reduce_if: controller handshake and RAM read port of the min/max reduction engine
// slave: the engine; master: the controller and RAM side
// start_in/mode/length in, busy/done_out/err_out/result/result_idx out; rd_en/rd_addr out, data in
interface minmax_reduce_if #(
  parameter int width = 10,
  parameter int addr_width = 10
);
  logic start_in;
  logic mode;
  logic [addr_width-1:0] length;
  logic [width-1:0] data;
  logic rd_en;
  logic [addr_width-1:0] rd_addr;
  logic busy;
  logic done_out;
  logic err_out;
  logic [width-1:0] result;
  logic [addr_width-1:0] result_idx;
  modport slave (
    input start_in, mode, length, data,
    output rd_en, rd_addr, busy, done_out, err_out, result, result_idx
  );
  modport master (
    output start_in, mode, length, data,
    input rd_en, rd_addr, busy, done_out, err_out, result, result_idx
  );
endinterface

// File: rtl/minmax_reduce.sv
// minmax_reduce: scans a vector in a synchronous RAM and returns its max or min value and index
// clk: rising-edge clock; rst: asynchronous active-low reset
// bus (slave): start_in/mode/length in, busy/done_out/err_out/result/result_idx out,
//              rd_en/rd_addr out to the RAM, data in from the RAM
module minmax_reduce #(
  parameter int width = 10,
  parameter int addr_width = 10,
  parameter int rd_latency = 1,
  parameter int signed_cmp = 0
) (
  input logic clk,
  input logic rst,
  minmax_reduce_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [addr_width-1:0] len, recv, addr, idx;
  logic [width-1:0] res;
  logic [rd_latency-1:0] vld;
  logic rd_en, mode_q, seen, accept, take, last_issue, last_take, gt, lt, better;
  assign accept = state == IDLE && bus.start_in;
  // vld[i] marks a request issued i+1 cycles ago; the top bit lines up with its RAM data
  assign take = vld[rd_latency-1];
  assign last_issue = addr == len - addr_width'(1);
  assign last_take = take && recv == len - addr_width'(1);
  assign gt = signed_cmp != 0 ? ($signed(bus.data) > $signed(res)) : (bus.data > res);
  assign lt = signed_cmp != 0 ? ($signed(bus.data) < $signed(res)) : (bus.data < res);
  assign better = mode_q ? lt : gt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = bus.length == '0 ? DONE : ISSUE;
    else if (state == ISSUE && last_issue) state_n = DRAIN;
    else if (state == DRAIN && last_take) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en <= 1'b0;
      addr <= '0;
      len <= '0;
      recv <= '0;
      idx <= '0;
      res <= '0;
      vld <= '0;
      mode_q <= 1'b0;
      seen <= 1'b0;
    end else begin
      rd_en <= state_n == ISSUE;
      vld <= rd_latency'({vld, rd_en});
      if (accept) begin
        len <= bus.length;
        mode_q <= bus.mode;
        addr <= '0;
        recv <= '0;
        seen <= 1'b0;
        res <= '0;
        idx <= '0;
      end else if (state == ISSUE && !last_issue) addr <= addr + addr_width'(1);
      // the first element loads unconditionally; later ones only on a strict win, so ties keep the earlier index
      if (take) begin
        recv <= recv + addr_width'(1);
        seen <= 1'b1;
        if (!seen || better) begin
          res <= bus.data;
          idx <= recv;
        end
      end
    end
  end
  assign bus.rd_en = rd_en;
  assign bus.rd_addr = addr;
  assign bus.busy = state == ISSUE || state == DRAIN;
  assign bus.done_out = state == DONE;
  assign bus.err_out = state == DONE && len == '0;
  assign bus.result = res;
  assign bus.result_idx = idx;
endmodule

// File: tb/tb_minmax_reduce.sv
// tb_minmax_reduce: directed checks of three minmax_reduce variants (lat 1 unsigned, lat 3 unsigned, lat 1 signed)
module tb_minmax_reduce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [9:0] length = '0;
  logic [9:0] mem [1024];
  int cyc = 0;
  int c0 = 0;
  int passed = 0;
  int total = 0;
  bit armed = 1'b0;
  int rc [3], rf [3], rl [3], dc [3], da [3], de [3];
  wire [2:0] rd_en, busy, done, err;
  wire [2:0][9:0] ra, res, idx;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  minmax_reduce_if #(.width(10), .addr_width(10)) b [3] ();
  for (genvar k = 0; k < 3; k++) begin : g
    logic [9:0] p [4];
    minmax_reduce #(
      .width(10),
      .addr_width(10),
      .rd_latency(k == 1 ? 3 : 1),
      .signed_cmp(k == 2 ? 1 : 0)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(b[k])
    );
    // RAM model: data for a request appears rd_latency cycles later; junk when nothing was read
    always @(posedge clk) begin
      p[0] <= b[k].rd_en ? mem[b[k].rd_addr] : 10'h2aa;
      for (int j = 1; j < 4; j++) p[j] <= p[j-1];
    end
    assign b[k].start_in = start;
    assign b[k].mode = mode;
    assign b[k].length = length;
    assign b[k].data = p[k == 1 ? 2 : 0];
    assign rd_en[k] = b[k].rd_en;
    assign ra[k] = b[k].rd_addr;
    assign busy[k] = b[k].busy;
    assign done[k] = b[k].done_out;
    assign err[k] = b[k].err_out;
    assign res[k] = b[k].result;
    assign idx[k] = b[k].result_idx;
  end
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (!armed) begin
        rc[k] = 0;
        rf[k] = -1;
        rl[k] = -1;
        dc[k] = 0;
        da[k] = -1;
        de[k] = 0;
      end else begin
        if (rd_en[k]) begin
          rc[k]++;
          if (rf[k] < 0) rf[k] = cyc - c0;
          rl[k] = cyc - c0;
        end
        if (done[k]) begin
          dc[k]++;
          if (da[k] < 0) begin
            da[k] = cyc - c0;
            de[k] = int'(err[k]);
          end
        end
      end
  task automatic run(input int n, input logic m, input int budget);
    armed = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    c0 = cyc;
    armed = 1'b1;
    start = 1'b1;
    mode = m;
    length = 10'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < budget && (da[0] < 0 || da[1] < 0 || da[2] < 0); c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total += 3;
      if ({rd_en[k], busy[k], done[k], err[k]} !== 4'b0) $display("FAIL reset_ctrl[%0d] got %b want 0000", k, {rd_en[k], busy[k], done[k], err[k]}); else passed++;
      if (ra[k] !== 10'd0) $display("FAIL reset_addr[%0d] got %0d want 0", k, ra[k]); else passed++;
      if ({res[k], idx[k]} !== 20'd0) $display("FAIL reset_result[%0d] got %0d/%0d want 0/0", k, res[k], idx[k]); else passed++;
    end
    #3 rst = 1'b1;
  endtask
  task automatic test_basic_max;
    int ed [3] = '{7, 9, 7};
    mem[0] = 10'd3;
    mem[1] = 10'd9;
    mem[2] = 10'd2;
    mem[3] = 10'd9;
    mem[4] = 10'd7;
    run(5, 1'b0, 40);
    for (int k = 0; k < 3; k++) begin
      total += 5;
      if (res[k] !== 10'd9) $display("FAIL basic_result[%0d] got %0d want 9", k, res[k]); else passed++;
      if (idx[k] !== 10'd1) $display("FAIL basic_idx[%0d] got %0d want 1", k, idx[k]); else passed++;
      if (da[k] !== ed[k]) $display("FAIL basic_done_cycle[%0d] got %0d want %0d", k, da[k], ed[k]); else passed++;
      if (de[k] !== 0 || dc[k] !== 1) $display("FAIL basic_err_pulses[%0d] got err %0d pulses %0d want 0 1", k, de[k], dc[k]); else passed++;
      if (busy[k] !== 1'b0) $display("FAIL basic_busy_after[%0d] got %b want 0", k, busy[k]); else passed++;
    end
  endtask
  task automatic test_min_latency;
    int ed [3] = '{6, 8, 6};
    mem[0] = 10'd12;
    mem[1] = 10'd5;
    mem[2] = 10'd8;
    mem[3] = 10'd5;
    run(4, 1'b1, 40);
    for (int k = 0; k < 3; k++) begin
      total += 4;
      if (res[k] !== 10'd5 || idx[k] !== 10'd1) $display("FAIL min_result[%0d] got %0d@%0d want 5@1", k, res[k], idx[k]); else passed++;
      if (da[k] !== ed[k]) $display("FAIL min_done_cycle[%0d] got %0d want %0d", k, da[k], ed[k]); else passed++;
      if (rf[k] !== 1 || rl[k] !== 4) $display("FAIL min_rd_en_window[%0d] got %0d..%0d want 1..4", k, rf[k], rl[k]); else passed++;
      if (rc[k] !== 4) $display("FAIL min_rd_en_count[%0d] got %0d want 4", k, rc[k]); else passed++;
    end
  endtask
  task automatic test_signed;
    logic [9:0] er [4][3] = '{'{10'h3ff, 10'h3ff, 10'h3ff}, '{10'h2d4, 10'h2d4, 10'h2d4},
                              '{10'd2, 10'd2, 10'h3fd}, '{10'h3fd, 10'h3fd, 10'd5}};
    logic [9:0] ei [4][3] = '{'{10'd1, 10'd1, 10'd1}, '{10'd2, 10'd2, 10'd2},
                              '{10'd2, 10'd2, 10'd1}, '{10'd1, 10'd1, 10'd0}};
    for (int t = 0; t < 4; t++) begin
      mem[0] = t < 2 ? 10'h3fc : 10'd5;
      mem[1] = t < 2 ? 10'h3ff : 10'h3fd;
      mem[2] = t < 2 ? 10'h2d4 : 10'd2;
      run(3, t == 1 || t == 2, 40);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (res[k] !== er[t][k] || idx[k] !== ei[t][k]) $display("FAIL signed_case%0d[%0d] got %h@%0d want %h@%0d", t, k, res[k], idx[k], er[t][k], ei[t][k]); else passed++;
      end
    end
  endtask
  task automatic test_zero_length;
    run(0, 1'b0, 20);
    for (int k = 0; k < 3; k++) begin
      total += 4;
      if (da[k] !== 1 || dc[k] !== 1) $display("FAIL zero_done[%0d] got cycle %0d pulses %0d want 1 1", k, da[k], dc[k]); else passed++;
      if (de[k] !== 1) $display("FAIL zero_err[%0d] got %0d want 1", k, de[k]); else passed++;
      if (rc[k] !== 0) $display("FAIL zero_rd_en[%0d] got %0d want 0", k, rc[k]); else passed++;
      if (res[k] !== 10'd0 || idx[k] !== 10'd0) $display("FAIL zero_result[%0d] got %0d@%0d want 0@0", k, res[k], idx[k]); else passed++;
    end
  endtask
  task automatic test_max_length;
    logic [9:0] er [2][3] = '{'{10'd1000, 10'd1000, 10'd100}, '{10'd3, 10'd3, 10'd1000}};
    logic [9:0] ei [2][3] = '{'{10'd500, 10'd500, 10'd0}, '{10'd1022, 10'd1022, 10'd500}};
    int ed [3] = '{1025, 1027, 1025};
    for (int i = 0; i < 1023; i++) mem[i] = 10'd100;
    mem[500] = 10'd1000;
    mem[1022] = 10'd3;
    for (int t = 0; t < 2; t++) begin
      run(1023, t == 1, 1100);
      for (int k = 0; k < 3; k++) begin
        total += 3;
        if (res[k] !== er[t][k] || idx[k] !== ei[t][k]) $display("FAIL maxlen_result%0d[%0d] got %0d@%0d want %0d@%0d", t, k, res[k], idx[k], er[t][k], ei[t][k]); else passed++;
        if (da[k] !== ed[k]) $display("FAIL maxlen_done%0d[%0d] got %0d want %0d", t, k, da[k], ed[k]); else passed++;
        if (rc[k] !== 1023) $display("FAIL maxlen_reads%0d[%0d] got %0d want 1023", t, k, rc[k]); else passed++;
      end
    end
  endtask
  task automatic test_reset_mid_scan;
    logic stray = 1'b0;
    armed = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 10'(50 + i);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode = 1'b0;
    length = 10'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total += 2;
    if (busy[0] !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy[0]); else passed++;
    if (res[0] !== 10'd51) $display("FAIL abort_result_before got %0d want 51", res[0]); else passed++;
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total += 2;
      if ({rd_en[k], busy[k], done[k], err[k]} !== 4'b0 || ra[k] !== 10'd0) $display("FAIL abort_ctrl[%0d] got %b addr %0d want 0000 addr 0", k, {rd_en[k], busy[k], done[k], err[k]}, ra[k]); else passed++;
      if ({res[k], idx[k]} !== 20'd0) $display("FAIL abort_result[%0d] got %0d@%0d want 0@0", k, res[k], idx[k]); else passed++;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (15) begin
      @(negedge clk);
      stray |= |done;
    end
    total++;
    if (stray !== 1'b0) $display("FAIL abort_no_done got %b want 0", stray); else passed++;
    mem[0] = 10'd1;
    mem[1] = 10'd6;
    run(2, 1'b0, 20);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (res[k] !== 10'd6 || idx[k] !== 10'd1) $display("FAIL abort_fresh[%0d] got %0d@%0d want 6@1", k, res[k], idx[k]); else passed++;
    end
  endtask
  task automatic test_back_to_back;
    logic [20:0] bv = '0;
    logic [20:0] dv = '0;
    logic [20:0] rv = '0;
    logic [9:0] r1 = '0;
    logic [9:0] i1 = '0;
    armed = 1'b0;
    mem[0] = 10'd4;
    mem[1] = 10'd8;
    mem[2] = 10'd1;
    mem[3] = 10'd6;
    mem[4] = 10'd2;
    mem[5] = 10'd1;
    mem[6] = 10'd7;
    @(posedge clk);
    #1;
    start = 1'b1;
    mode = 1'b0;
    length = 10'd3;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        mode = 1'b1;
        length = 10'd7;
      end
      if (c == 8) begin
        mode = 1'b0;
        length = 10'd2;
      end
      if (c == 14) start = 1'b0;
      @(negedge clk);
      bv[c] = busy[0];
      dv[c] = done[0];
      rv[c] = rd_en[0];
      if (done[0] && c < 10) begin
        r1 = res[0];
        i1 = idx[0];
      end
    end
    total += 5;
    if (dv !== 21'h08020) $display("FAIL b2b_done_cycles got %h want 08020", dv); else passed++;
    if (bv !== 21'h07f9e) $display("FAIL b2b_busy_cycles got %h want 07f9e", bv); else passed++;
    if (rv !== 21'h03f8e) $display("FAIL b2b_rd_en_cycles got %h want 03f8e", rv); else passed++;
    if (r1 !== 10'd8 || i1 !== 10'd1) $display("FAIL b2b_first_result got %0d@%0d want 8@1", r1, i1); else passed++;
    if (res[0] !== 10'd1 || idx[0] !== 10'd2) $display("FAIL b2b_second_result got %0d@%0d want 1@2", res[0], idx[0]); else passed++;
  endtask
  initial begin
    test_reset;
    test_basic_max;
    test_min_latency;
    test_signed;
    test_zero_length;
    test_max_length;
    test_reset_mid_scan;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/minmax_reduce.md
Name: minmax_reduce

Overview:
- Parametrised stream reduction engine that scans a vector held in an external synchronous RAM and returns its maximum or minimum value, plus the index of that element.
- Generalises the single-mode max scanner with the following additions:
  - run-time max/min mode;
  - signed or unsigned comparison;
  - configurable RAM read latency;
  - argmax/argmin index output;
  - a zero-length error flag.
- Sits between the vector buffer RAM and the stream-computation controller, which drives the start_in/done_out handshake.

Parameters:
- width, 10, data bit width of each element
- addr_width, 10, bit width of length, rd_addr and result_idx
- rd_latency, 1, cycles from rd_en asserted to data valid; legal range 1..4
- signed_cmp, 0, 1 = compare as two's complement, 0 = unsigned

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- start_in  in  1  start pulse; sampled only in IDLE
- mode  in  1  0 = max, 1 = min; latched at start
- length  in  addr_width  number of elements N; latched at start
- data  in  width  RAM read data
- rd_en  out  1  RAM read enable, registered
- rd_addr  out  addr_width  RAM read address, registered
- busy  out  1  high from the cycle after start is accepted until done_out
- done_out  out  1  one-cycle completion pulse
- err_out  out  1  high with done_out when N == 0
- result  out  width  extreme value, held until the next accepted start
- result_idx  out  addr_width  index of the extreme value, held until the next accepted start

Behaviour:
- Reset:
  - rst low at any time, including mid-scan, asynchronously forces IDLE.
  - All outputs go to 0; internal counters, valid pipeline and accumulator clear.
  - No completion pulse is produced for an aborted scan.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - rd_en = 0.
  - When start_in = 1 at a rising edge: latch length and mode, clear issue and receive counters, clear the first-element flag.
  - Next state is ISSUE, or DONE if the latched N == 0.
- ISSUE:
  - rd_en = 1 and rd_addr = issue counter (0, 1, ... N-1), one request per cycle.
  - After the request with address N-1 is issued, go to DRAIN.
- DRAIN:
  - rd_en = 0, rd_addr holds its last value.
  - Stay until the receive counter reaches N, then go to DONE.
- Valid pipeline:
  - A rd_latency-deep shift register tracks outstanding requests.
  - Data for the request issued in cycle t is valid in cycle t + rd_latency and is consumed at the end of that cycle.
  - Data may arrive while still in ISSUE; the receive index increments with every consumed element.
- Compare rule:
  - The first consumed element loads result and result_idx unconditionally.
  - After that, result is updated only if data > result (max) or data < result (min), strictly.
  - Ties keep the earlier index.
  - Comparison is signed when signed_cmp = 1, otherwise unsigned.
- DONE:
  - done_out = 1 for exactly one cycle; busy drops in the same cycle.
  - err_out = 1 in that cycle if N == 0; in that case result and result_idx are 0.
  - Next state is IDLE.
- Latency: with start_in sampled in cycle 0, rd_en is high in cycles 1..N and done_out is high in cycle N + rd_latency + 1.
- start_in outside IDLE is ignored; a new start may be accepted in the cycle after done_out.
- mode and length changes after the start cycle have no effect on the running scan.
- N = 2^addr_width - 1 (maximum) must complete correctly.
- result and result_idx change only during a scan; between scans they hold the last completed values.

Test Plan:
- Basic max: rd_latency = 1, unsigned, mode = 0, N = 5, RAM = {3, 9, 2, 9, 7} -> done_out in cycle 7, result = 9, result_idx = 1 (tie keeps the earlier index), err_out = 0.
- Min with long latency: rd_latency = 3, mode = 1, N = 4, RAM = {12, 5, 8, 5} -> result = 5, result_idx = 1, done_out in cycle 8; rd_en high in exactly cycles 1..4.
- Signed compare: signed_cmp = 1, width = 10, mode = 0, N = 3, RAM = {-4, -1, -300} -> result = -1 (0x3FF), result_idx = 1. Same data with signed_cmp = 0 -> result = 0x3FF; with mode = 1 and signed_cmp = 0 -> result = 0x2D4 (-300), result_idx = 2.
- Zero length: N = 0, start_in pulse -> no rd_en, done_out and err_out high in cycle 1, result = 0, result_idx = 0.
- Reset mid-scan: N = 8, assert rst low in cycle 4 between clock edges -> all outputs 0 immediately. No done_out follows. A fresh start with N = 2, RAM = {1, 6} -> result = 6, result_idx = 1.
- Handshake robustness: hold start_in high continuously and toggle mode/length during the scan -> the scan uses its latched values. A second scan starts in the cycle after done_out, and busy is low only in the DONE→IDLE cycle.
